hamming_rx_decoder: RTL and testbench
=====================================

HAMMING_RX_DECODER -- requirements
Module: hamming_rx_decoder

Interface
REQ-001 clk  input  1  rising-edge system clock.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 bit_in  input  1  serial Hamming(15,11) codeword bit, sampled when bit_valid=1.
REQ-004 bit_valid  input  1  qualifies bit_in for one cycle.
REQ-005 frame_start  input  1  marks bit_in as codeword position 1; ignored unless bit_valid=1.
REQ-006 data_out  output  11  corrected data word.
REQ-007 syndrome  output  4  syndrome of the delivered word; 0 means no error.
REQ-008 corrected  output  1  1 when the delivered word had one bit flipped.
REQ-009 out_valid  output  1  data_out, syndrome and corrected are valid.
REQ-010 out_ready  input  1  consumer accepts the word when out_valid=1 and out_ready=1.
REQ-011 overrun  output  1  sticky flag: a completed codeword was dropped.

Function
REQ-012 Codeword positions 1..15 SHALL arrive in order, with position 1 first; positions 1, 2, 4 and 8 are parity; data d[0..10] maps to positions 3,5,6,7,9,10,11,12,13,14,15.
REQ-013 The collector FSM SHALL have two states, IDLE and SHIFT; IDLE->SHIFT on bit_valid&frame_start, with count=1.
REQ-014 In SHIFT, each bit_valid SHALL store bit_in at position count+1 and increment count; cycles without bit_valid hold state.
REQ-015 frame_start&bit_valid in SHIFT SHALL discard the partial word and restart at position 1; no output and no flag results.
REQ-016 Acceptance of position 15 SHALL complete the word: the word is loaded into a one-entry check register and the FSM goes to IDLE, or to SHIFT if that same bit carries frame_start.
REQ-017 Syndrome bit k SHALL be the XOR of all positions whose index has bit k set; a nonzero syndrome S inverts position S before data extraction.
REQ-018 When the check register is full and the output register is free (out_valid=0, or out_ready=1 in the same cycle), the decoded result SHALL load into the output register on the next edge.
REQ-019 Latency: position 15 is sampled at edge N; out_valid=1 with the result after edge N+1 when the output register is free.
REQ-020 out_valid SHALL stay high, with outputs stable, until an out_valid&out_ready edge; simultaneous acceptance and refill in the same cycle is allowed, giving no bubble.
REQ-021 A word completing while the check register is full and cannot drain that cycle SHALL be dropped and set overrun; the held words are unaffected.
REQ-022 overrun SHALL remain 1 until reset.

Reset
REQ-023 rst_n=0 SHALL immediately force FSM=IDLE, count=0, the check register empty, out_valid=0, data_out=0, syndrome=0, corrected=0 and overrun=0.
REQ-024 Reset mid-frame SHALL discard the partial word; the first output after release comes from a fresh frame_start.

Configuration
REQ-025 With HAMMING_RX_ERRCNT_EN defined, the module SHALL add the output err_count [7:0], which increments on every delivered word with corrected=1, saturates at 255, and resets to 0.
REQ-026 Without HAMMING_RX_ERRCNT_EN, err_count SHALL be absent and no counter logic SHALL be built.

Verification
REQ-027 Send 15'h0000 with out_ready=1 -> data_out=11'h000, syndrome=0, corrected=0, out_valid one cycle after the last bit.
REQ-028 Send 15'h7FFF (data 11'h7FF) with position 5 inverted -> data_out=11'h7FF, syndrome=5, corrected=1, err_count=1 when the macro is defined.
REQ-029 Hold out_ready=0 and send three back-to-back words -> the first is held in the output register, the second in the check register, the third is dropped with overrun=1; then raise out_ready -> words 1 and 2 are delivered in order.
REQ-030 Send 7 bits, then frame_start with a full codeword of data 11'h7FF -> a single output, data_out=11'h7FF, overrun=0.
REQ-031 Assert rst_n=0 at bit 9 of a word, then send a complete word of data 11'h000 -> a single output, data_out=11'h000, with no artefact from the aborted word.
REQ-032 With the macro defined, send 260 words each with a single-bit error -> err_count saturates at 255.

Source files
------------

// File: rtl/hamming_rx_decoder.sv
`default_nettype none
// hamming_rx_decoder: serial Hamming(15,11) receiver, single-error correction, 1-deep check stage + output register. Rev 1.0
// Define HAMMING_RX_ERRCNT_EN to add the saturating err_count output.

module hamming_rx_decoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bit_in,
  input  logic        bit_valid,
  input  logic        frame_start,
  output logic [10:0] data_out,
  output logic [3:0]  syndrome,
  output logic        corrected,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overrun
`ifdef HAMMING_RX_ERRCNT_EN
  ,
  output logic [7:0]  err_count
`endif
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Bit k of a position index selects the positions covered by syndrome bit k.
  localparam logic [14:0] SYN_MASK0 = 15'h5555;
  localparam logic [14:0] SYN_MASK1 = 15'h6666;
  localparam logic [14:0] SYN_MASK2 = 15'h7878;
  localparam logic [14:0] SYN_MASK3 = 15'h7F80;

  state_t      state;
  logic [3:0]  count;
  logic [14:0] shift_word;
  logic        chk_full;
  logic [14:0] chk_word;

  logic        word_done;
  logic        out_free;
  logic        drain;
  logic [3:0]  syn_c;
  logic [14:0] flip_c;
  logic [14:0] fixed_c;
  logic [10:0] data_c;

  // Position 15 completes the word even when it also carries frame_start.
  assign word_done = (state == SHIFT) && bit_valid && (count == 4'd14);
  assign out_free  = !out_valid || out_ready;
  assign drain     = chk_full && out_free;

  always_comb begin
    syn_c[0] = ^(chk_word & SYN_MASK0);
    syn_c[1] = ^(chk_word & SYN_MASK1);
    syn_c[2] = ^(chk_word & SYN_MASK2);
    syn_c[3] = ^(chk_word & SYN_MASK3);
    flip_c   = (syn_c == 4'd0) ? 15'd0 : (15'd1 << (syn_c - 4'd1));
    fixed_c  = chk_word ^ flip_c;
    data_c   = {fixed_c[14:8], fixed_c[6:4], fixed_c[2]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= 4'd0;
      shift_word <= 15'd0;
    end else if (bit_valid) begin
      if (frame_start) begin
        state      <= SHIFT;
        count      <= 4'd1;
        shift_word <= {14'd0, bit_in};
      end else if (state == SHIFT) begin
        shift_word[count] <= bit_in;
        if (count == 4'd14) begin
          state <= IDLE;
          count <= 4'd0;
        end else begin
          count <= count + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_full  <= 1'b0;
      chk_word  <= 15'd0;
      out_valid <= 1'b0;
      data_out  <= 11'd0;
      syndrome  <= 4'd0;
      corrected <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (word_done && (!chk_full || drain)) begin
        chk_full <= 1'b1;
        chk_word <= {bit_in, shift_word[13:0]};
      end else if (drain) begin
        chk_full <= 1'b0;
      end

      if (word_done && chk_full && !drain) begin
        overrun <= 1'b1;
      end

      if (drain) begin
        out_valid <= 1'b1;
        data_out  <= data_c;
        syndrome  <= syn_c;
        corrected <= (syn_c != 4'd0);
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef HAMMING_RX_ERRCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= 8'd0;
    end else if (out_valid && out_ready && corrected && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_hamming_rx_decoder.sv
`default_nettype none
// tb_hamming_rx_decoder: directed and randomized checks of hamming_rx_decoder against an encoder-based reference model.

module tb_hamming_rx_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bit_in = 1'b0;
  logic        bit_valid = 1'b0;
  logic        frame_start = 1'b0;
  logic        out_ready = 1'b0;
  logic [10:0] data_out;
  logic [3:0]  syndrome;
  logic        corrected;
  logic        out_valid;
  logic        overrun;
`ifdef HAMMING_RX_ERRCNT_EN
  logic [7:0]  err_count;
`endif

  hamming_rx_decoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bit_in      (bit_in),
    .bit_valid   (bit_valid),
    .frame_start (frame_start),
    .data_out    (data_out),
    .syndrome    (syndrome),
    .corrected   (corrected),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .overrun     (overrun)
`ifdef HAMMING_RX_ERRCNT_EN
    ,
    .err_count   (err_count)
`endif
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mon_e;
  int          rdy_mode = 1;
  int          stall_run = 0;
  logic [10:0] w1, w2, w3;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference encoder: data at non-power-of-two positions, parity p=2^k covers positions with bit k set.
  function automatic logic [14:0] encode(input logic [10:0] d);
    int          dpos[11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};
    logic [15:0] cw = 16'd0;
    logic        par;
    for (int i = 0; i < 11; i++) cw[dpos[i]] = d[i];
    for (int k = 0; k < 4; k++) begin
      par = 1'b0;
      for (int p = 1; p < 16; p++)
        if (((p >> k) & 1) == 1 && p != (1 << k)) par = par ^ cw[p];
      cw[1 << k] = par;
    end
    return cw[15:1];
  endfunction

  task automatic send_bit(input logic b, input logic fs);
    bit_in      = b;
    frame_start = fs;
    bit_valid   = 1'b1;
    @(posedge clk); #1;
    bit_valid   = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic send_word(input logic [10:0] d, input int err, input bit expect_out, input int max_gap);
    logic [14:0] cw;
    cw = encode(d);
    if (err != 0) cw[err-1] = ~cw[err-1];
    if (expect_out) exp_q.push_back({d, 4'(err), err != 0});
    for (int p = 1; p < 16; p++) begin
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) begin @(posedge clk); #1; end
      send_bit(cw[p-1], p == 1);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check("drain_queue", 32'(exp_q.size()), 32'd0);
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: out_ready = 1'b0;
      1: out_ready = 1'b1;
      default: begin
        if (stall_run >= 3 || $urandom_range(0, 1) == 1) begin
          out_ready = 1'b1;
          stall_run = 0;
        end else begin
          out_ready = 1'b0;
          stall_run++;
        end
      end
    endcase
  end

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", 32'(exp_q.size()), 32'd1);
      end else begin
        mon_e = exp_q.pop_front();
        check("data_out", 32'(data_out), 32'(mon_e[15:5]));
        check("syndrome", 32'(syndrome), 32'(mon_e[4:1]));
        check("corrected", 32'(corrected), 32'(mon_e[0]));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_syndrome", 32'(syndrome), 32'd0);
    check("rst_corrected", 32'(corrected), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // All-zero word and its one-cycle latency
    send_word(11'h000, 0, 1'b1, 0);
    check("lat_not_yet", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_valid", 32'(out_valid), 32'd1);
    check("lat_data", 32'(data_out), 32'd0);
    wait_idle();

    // All-ones word with position 5 inverted
    send_word(11'h7FF, 5, 1'b1, 0);
    wait_idle();
`ifdef HAMMING_RX_ERRCNT_EN
    check("errcnt_one", 32'(err_count), 32'd1);
`endif

    // Three back-to-back words against a stalled consumer
    rdy_mode = 0;
    repeat (2) @(posedge clk); #1;
    w1 = 11'($urandom);
    w2 = 11'($urandom);
    w3 = 11'($urandom);
    send_word(w1, 0, 1'b1, 0);
    send_word(w2, 3, 1'b1, 0);
    send_word(w3, 0, 1'b0, 0);
    repeat (3) @(posedge clk); #1;
    check("ovr_set", 32'(overrun), 32'd1);
    check("held_valid", 32'(out_valid), 32'd1);
    check("held_data", 32'(data_out), 32'(w1));
    rdy_mode = 1;
    wait_idle();
    check("ovr_sticky", 32'(overrun), 32'd1);

    rst_n = 1'b0;
    #3;
    check("ovr_async_clear", 32'(overrun), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Truncated frame followed by a restart
    for (int p = 1; p <= 7; p++) send_bit(1'($urandom), p == 1);
    send_word(11'h7FF, 0, 1'b1, 0);
    wait_idle();
    check("restart_no_ovr", 32'(overrun), 32'd0);

    // Reset during bit 9 of a word
    for (int p = 1; p <= 8; p++) send_bit(1'($urandom), p == 1);
    bit_in    = 1'b1;
    bit_valid = 1'b1;
    rst_n     = 1'b0;
    @(posedge clk); #1;
    bit_valid = 1'b0;
    rst_n     = 1'b1;
    @(posedge clk); #1;
    send_word(11'h000, 0, 1'b1, 0);
    wait_idle();
    check("abort_no_ovr", 32'(overrun), 32'd0);

    // Asynchronous reset clears a held output without a clock edge
    rdy_mode = 0;
    repeat (2) @(posedge clk); #1;
    send_word(11'h5A5, 0, 1'b0, 0);
    @(posedge clk); #1;
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_data", 32'(data_out), 32'd0);
    @(posedge clk); #1;
    rst_n    = 1'b1;
    rdy_mode = 1;
    @(posedge clk); #1;

    // Random words, random gaps, random bounded back-pressure
    rdy_mode = 2;
    repeat (40) send_word(11'($urandom), int'($urandom_range(0, 15)), 1'b1, 2);
    rdy_mode = 1;
    wait_idle();
    check("random_no_ovr", 32'(overrun), 32'd0);

`ifdef HAMMING_RX_ERRCNT_EN
    repeat (260) send_word(11'($urandom), int'($urandom_range(1, 15)), 1'b1, 0);
    wait_idle();
    check("errcnt_saturate", 32'(err_count), 32'd255);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
